// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: PSR owner, Bcond/Jcond resolver with a one-entry registered valid/ready output stage.
// Optional BRU_STATS_EN adds saturating branch/taken statistics counters.
module branch_resolve_unit #(
  parameter int PC_W    = 16,
  parameter int DISP_W  = 8,
  parameter int STATS_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     instr,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] rtarget,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      psr_we,
  input  logic [4:0]      psr_wdata,
  input  logic            flush,
  output logic [4:0]      psr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [PC_W-1:0] out_target,
  output logic            out_is_branch
`ifdef BRU_STATS_EN
  ,
  output logic [STATS_W-1:0] stat_branches,
  output logic [STATS_W-1:0] stat_taken
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [4:0] eff_psr;
  logic [15:0] conds;
  logic is_bcond, is_jcond, is_br, cond, taken, accept;
  logic [PC_W-1:0] disp, target;
  assign eff_psr = (psr_we & psr_wdata) | (~psr_we & psr);
  // Indexed by condition code; eff_psr order is C L F Z N
  assign conds = {1'b0, 1'b1,
                  eff_psr[0] | eff_psr[1], ~eff_psr[1] & ~eff_psr[0],
                  eff_psr[3] | eff_psr[1], ~eff_psr[3] & ~eff_psr[1],
                  ~eff_psr[2], eff_psr[2],
                  ~eff_psr[0], eff_psr[0],
                  ~eff_psr[3], eff_psr[3],
                  ~eff_psr[4], eff_psr[4],
                  ~eff_psr[1], eff_psr[1]};
  assign is_bcond = instr[15:12] == 4'b1100;
  assign is_jcond = instr[15:12] == 4'b0100 && instr[7:4] == 4'b1100;
  assign is_br    = is_bcond | is_jcond;
  assign cond     = conds[instr[11:8]];
  assign taken    = is_br & cond;
  assign disp     = PC_W'($signed(instr[DISP_W-1:0]));
  assign target   = !taken ? pc + PC_W'(1) : is_bcond ? pc + disp : rtarget;
  assign accept   = in_valid & in_ready & ~flush;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  always_comb begin
    state_nxt = flush ? EMPTY : accept ? FULL : (state == FULL && !out_ready) ? FULL : EMPTY;
  end
  always_comb begin
    out_valid = state == FULL;
    in_ready  = !out_valid | out_ready;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      psr           <= '0;
      out_taken     <= 1'b0;
      out_target    <= '0;
      out_is_branch <= 1'b0;
    end else begin
      psr <= eff_psr;
      if (accept) begin
        out_taken     <= taken;
        out_target    <= target;
        out_is_branch <= is_br;
      end
    end
`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else begin
      if (accept && is_br && !(&stat_branches)) stat_branches <= stat_branches + STATS_W'(1);
      if (accept && taken && !(&stat_taken))    stat_taken    <= stat_taken + STATS_W'(1);
    end
`endif
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Successor to the combinational condition decoder. Owns the architectural PSR (C L F Z N), evaluates conditions for Bcond/Jcond, computes the redirect target, and registers the decision in one pipeline stage with a valid/ready handshake toward fetch.
- Sits between decode/execute and the PC/fetch logic.

Parameters:
PC_W, 16, program-counter and target width (>= DISP_W)
DISP_W, 8, Bcond displacement width taken from instr[DISP_W-1:0], sign-extended
STATS_W, 16, width of statistics counters (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
instr  input  16  instruction under evaluation
pc  input  PC_W  address of instr
rtarget  input  PC_W  Jcond target register value, already read by decode
in_valid  input  1  instr/pc/rtarget valid
in_ready  output  1  unit can accept instr this cycle
psr_we  input  5  per-bit PSR write enable from ALU, bit order C L F Z N = [4:0]
psr_wdata  input  5  new flag values from ALU
flush  input  1  cancel the held result and the incoming instr
psr  output  5  current architectural PSR
out_valid  output  1  registered decision valid
out_ready  input  1  consumer accepts decision
out_taken  output  1  branch/jump taken
out_target  output  PC_W  redirect address, valid when out_taken
out_is_branch  output  1  held instr was a Bcond or Jcond (0 = pass-through non-branch)

Behaviour:
- Reset (async, reset_n low): psr=5'b0, out_valid=0, out_taken=0, out_target=0, out_is_branch=0, counters=0. in_ready reads 1 once reset_n is high.
- Classification: Bcond when instr[15:12]==4'b1100. Jcond when instr[15:12]==4'b0100 and instr[7:4]==4'b1100. Anything else is a non-branch: accepted, out_is_branch=0, out_taken=0.
- Condition code instr[11:8], with C=psr[4] L=psr[3] F=psr[2] Z=psr[1] N=psr[0]:
  - 0 EQ Z; 1 NE !Z
  - 2 CS C; 3 CC !C
  - 4 HI L; 5 LS !L
  - 6 GT N; 7 LE !N
  - 8 FS F; 9 FC !F
  - 10 LO !L&!Z; 11 HS L|Z
  - 12 LT !Z&!N; 13 GE N|Z
  - 14 UC 1; 15 never (taken=0)
- Flag bypass: evaluation uses eff_psr[i] = psr_we[i] ? psr_wdata[i] : psr[i]. An ALU write in the same cycle as acceptance is visible to that branch.
- PSR register: each bit with psr_we[i]=1 updates at the clock edge. Updates occur regardless of handshake state and of flush.
- Targets:
  - Bcond: pc + sign_extend(instr[DISP_W-1:0]), modulo 2^PC_W, wraps silently.
  - Jcond: rtarget.
  - Not-taken or non-branch: out_target = pc + 1 (wraps).
- Handshake:
  - in_ready = !out_valid | out_ready (single-entry pipeline register, no bubble on continuous flow).
  - Accept when in_valid & in_ready & !flush. Outputs load at that edge, so latency is 1 cycle.
  - out_* held stable while out_valid & !out_ready.
  - out_valid clears on out_ready with no new accept.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on accept.
  - FULL->FULL on out_ready & accept.
  - FULL->EMPTY on out_ready & !accept.
  - FULL held on !out_ready.
- flush: next cycle out_valid=0 and no accept that cycle. in_ready is unaffected combinationally. flush has priority over every other event.
- reset_n asserted mid-transaction drops everything immediately, with no partial update.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined:
  - Adds outputs stat_branches, stat_taken (STATS_W each).
  - stat_branches increments on each accepted Bcond/Jcond.
  - stat_taken increments on each accepted taken one.
  - Both saturate at all-ones and reset to 0. Flushed instructions are not counted.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> psr=0, out_valid=0. Release -> in_ready=1.
- Bypass: psr=0, same cycle psr_we=5'b00010, psr_wdata=5'b00010, instr=16'hC0FE, pc=16'h0010 -> next cycle out_valid=1, out_taken=1, out_target=16'h000E, psr=5'b00010.
- Jcond GE: psr N=1, instr=16'h4DC3, rtarget=16'h1234 -> out_taken=1, out_target=16'h1234. Repeat with psr=0 -> out_taken=0, out_target=pc+1.
- Backpressure: out_ready=0 for 3 cycles after accept -> in_ready=0 and out_* stable. Raise out_ready with a new in_valid -> back-to-back accept with no bubble.
- Flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, that instr not accepted.
- Wrap: PC_W=16, pc=16'hFFFF, instr=16'hCE02 -> out_target=16'h0001. With BRU_STATS_EN: stat_branches=1, stat_taken=1.
